// File: rtl/conv2d_psum_buf_pkg.sv
// rtl/conv2d_psum_buf_pkg.sv - shared constants for the conv2d partial-sum buffer
//
// Purpose : data-path width and the value substituted by ReLU.
// Ports   : none (package).
package conv2d_psum_buf_pkg;

  localparam int FP_W = 32;
  // ReLU output for negative inputs; also maps -0.0 to +0.0.
  localparam logic [FP_W-1:0] RELU_ZERO = '0;

endpackage

// File: rtl/conv2d_psum_buf_psum_ram.sv
// rtl/conv2d_psum_buf_psum_ram.sv - simple dual-port psum RAM with registered read
//
// Purpose : 32 x 2**AW storage, one write port and one read port.
// Ports   : clk_i                       clock
//           we_i / waddr_i / wdata_i    write port
//           re_i / raddr_i              read request and address
//           rdata_o                     read data, valid 1 cycle after re_i; holds otherwise
module psum_ram
  import conv2d_psum_buf_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [FP_W-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [FP_W-1:0] rdata_o
);

  logic [FP_W-1:0] mem_q [2**AW];
  logic [FP_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv2d_psum_buf.sv
// rtl/conv2d_psum_buf.sv - partial-sum capture/replay buffer behind the conv2d core
//
// Purpose : stores the core's accumulated stream for every input channel but the
//           last and replays it as the next channel's accumulate input. On the
//           last channel it crops the invalid edge columns, applies optional
//           ReLU and emits the output-feature-map pixels. Never stalls.
// Ports   : clk, rst                    clock, synchronous active-high reset
//           param_ena + param_*         latch frame parameters (also soft clear)
//           pxl_ena_y -> pxl_y          replay read request / partial sum (1 cycle later)
//           pxl_ena_z, pxl_z            accumulated result from the core
//           out_ena, out_data, out_done final pixel stream, end-of-frame pulse
//           err_ovf, err_udf            sticky overflow / underflow flags
module conv2d_psum_buf
  import conv2d_psum_buf_pkg::*;
#(
  parameter int C_WIDTH = 9,
  parameter int C_CH    = 10,
  parameter int KS      = 3,
  parameter int AW      = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               param_ena,
  input  logic [C_WIDTH-1:0] param_width_in,
  input  logic [C_WIDTH-1:0] param_height_in,
  input  logic [C_CH-1:0]    param_ch_in,
  input  logic               param_relu,
  input  logic               pxl_ena_y,
  output logic [FP_W-1:0]    pxl_y,
  input  logic               pxl_ena_z,
  input  logic [FP_W-1:0]    pxl_z,
  output logic               out_ena,
  output logic [FP_W-1:0]    out_data,
  output logic               out_done,
  output logic               err_ovf,
  output logic               err_udf
);

  localparam int NW = 2 * C_WIDTH;
  localparam logic [C_WIDTH-1:0] KS_M1 = C_WIDTH'(KS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Latched frame parameters (kept across rst; only param_ena reloads them).
  logic [C_WIDTH-1:0] width_m1_q;
  logic [C_CH-1:0]    ch_last_q;
  logic [NW-1:0]      n_last_q;
  logic               relu_q;

  state_e             state_q;
  logic [C_CH-1:0]    rd_ch_q, wr_ch_q;
  logic [NW-1:0]      rd_cnt_q, wr_cnt_q;
  logic [C_WIDTH-1:0] col_q;
  logic [AW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [AW:0]        count_q;
  logic               y_zero_q;
  logic               out_ena_q, out_done_q;
  logic [FP_W-1:0]    out_data_q;
  logic               err_ovf_q, err_udf_q;

  logic               active, rd_req, wr_req, wr_final, empty, full;
  logic               rd_fire, wr_fire, rd_udf, wr_ovf;
  logic               rd_wrap, wr_wrap, col_wrap, frame_end, crop_keep;
  logic [FP_W-1:0]    relu_data, ram_rdata;

  // Requests are ignored in DONE and in the clearing cycle itself.
  assign active    = (state_q != ST_DONE) && !rst && !param_ena;
  assign rd_req    = active && pxl_ena_y;
  assign wr_req    = active && pxl_ena_z;
  assign wr_final  = (wr_ch_q == ch_last_q);

  // Full/empty come from the pre-cycle count: no write-to-read bypass.
  assign empty     = (count_q == '0);
  assign full      = count_q[AW];
  assign rd_fire   = rd_req && (rd_ch_q != '0) && !empty;
  assign rd_udf    = rd_req && (rd_ch_q != '0) && empty;
  assign wr_fire   = wr_req && !wr_final && !full;
  assign wr_ovf    = wr_req && !wr_final && full;

  assign rd_wrap   = (rd_cnt_q == n_last_q);
  assign wr_wrap   = (wr_cnt_q == n_last_q);
  assign col_wrap  = (col_q == width_m1_q);
  assign frame_end = wr_req && wr_final && wr_wrap;
  assign crop_keep = (col_q >= KS_M1);
  assign relu_data = (relu_q && pxl_z[FP_W-1]) ? RELU_ZERO : pxl_z;

  psum_ram #(.AW(AW)) u_ram (
    .clk_i   (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (pxl_z),
    .re_i    (rd_fire),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // First channel, underflow and post-reset all present zero; the RAM read
  // register is left unreset, so the zero is selected here instead.
  assign pxl_y = y_zero_q ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (param_ena) begin
      width_m1_q <= param_width_in - C_WIDTH'(1);
      ch_last_q  <= param_ch_in - C_CH'(1);
      n_last_q   <= NW'(param_height_in - KS_M1) * NW'(param_width_in) - NW'(1);
      relu_q     <= param_relu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || param_ena) begin
      state_q    <= ST_IDLE;
      rd_ch_q    <= '0;
      wr_ch_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      col_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      y_zero_q   <= 1'b1;
      out_ena_q  <= 1'b0;
      out_done_q <= 1'b0;
      out_data_q <= '0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
    end else begin
      out_ena_q  <= 1'b0;
      out_done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (frame_end) begin
            state_q <= ST_DONE;
          end else if (rd_req || wr_req) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (frame_end) begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_DONE;
      endcase

      if (rd_req) begin
        y_zero_q <= !rd_fire;
        if (rd_fire) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        if (rd_udf) begin
          err_udf_q <= 1'b1;
        end
        if (rd_wrap) begin
          rd_cnt_q <= '0;
          rd_ch_q  <= rd_ch_q + C_CH'(1);
        end else begin
          rd_cnt_q <= rd_cnt_q + NW'(1);
        end
      end

      if (wr_req) begin
        if (wr_fire) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (wr_ovf) begin
          err_ovf_q <= 1'b1;
        end
        if (wr_final && crop_keep) begin
          out_ena_q  <= 1'b1;
          out_data_q <= relu_data;
        end
        out_done_q <= frame_end;
        col_q      <= col_wrap ? '0 : col_q + C_WIDTH'(1);
        if (wr_wrap) begin
          wr_cnt_q <= '0;
          wr_ch_q  <= wr_ch_q + C_CH'(1);
        end else begin
          wr_cnt_q <= wr_cnt_q + NW'(1);
        end
      end

      // Simultaneous read and write leaves occupancy unchanged.
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_ena  = out_ena_q;
  assign out_data = out_data_q;
  assign out_done = out_done_q;
  assign err_ovf  = err_ovf_q;
  assign err_udf  = err_udf_q;

endmodule

// File: doc/conv2d_psum_buf.md
# conv2d_psum_buf

Partial-sum buffer placed directly downstream of the 2-D convolution core. It captures the core's accumulated output stream (`pxl_z`) for every input channel except the last, and replays it in order as the core's accumulate input (`pxl_y`) for the next input channel. On the last input channel it crops the invalid edge columns, optionally applies ReLU, and emits the final output-feature-map pixels. The core has no backpressure, so this block never stalls; it flags overflow and underflow instead.

## Interface
Parameters:
- `C_WIDTH`, 9: width of the image width/height fields.
- `C_CH`, 10: width of the input-channel count field.
- `KS`, 3: kernel size. Sets the number of rows and columns cropped.
- `AW`, 12: psum RAM address width. Depth is 2**AW words of 32 bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `param_ena`  in  1  latch params; same soft-clear as `rst`.
- `param_width_in`  in  C_WIDTH  image width W (≥ KS).
- `param_height_in`  in  C_WIDTH  image height H (≥ KS).
- `param_ch_in`  in  C_CH  input channel count C (≥ 1).
- `param_relu`  in  1  enable ReLU on the final output.
- `pxl_ena_y`  in  1  read request from the core.
- `pxl_y`  out  32  partial sum to the core (FP32).
- `pxl_ena_z`  in  1  core accumulated-result valid.
- `pxl_z`  in  32  core accumulated result (FP32).
- `out_ena`  out  1  final pixel valid.
- `out_data`  out  32  final pixel (FP32).
- `out_done`  out  1  one-cycle pulse with the last pixel of the frame.
- `err_ovf`  out  1  sticky: write attempted while the RAM is full.
- `err_udf`  out  1  sticky: read attempted while the RAM is empty.

## Operation
- **Reset / `param_ena`.** Clears pointers, counters and flags. All outputs go to 0. Params are latched on `param_ena`. Per-channel beat count is N = (H−KS+1)·W.
- **Two independent channel trackers.**
  - Read side: `rd_ch` with a beat counter `rd_cnt`.
  - Write side: `wr_ch` with `wr_cnt` and a column counter `col` (0..W−1).
  - Each beat counter wraps at N and then increments its channel index.
- **Read, on `pxl_ena_y` = 1.**
  - If `rd_ch` = 0: no RAM read; `pxl_y` = 0.
  - Otherwise: read the RAM at the read pointer and advance the pointer.
  - If the RAM is empty: `pxl_y` = 0, no pointer move, set `err_udf`.
- **Write, on `pxl_ena_z` = 1.**
  - If `wr_ch` < C−1: write `pxl_z` at the write pointer and advance it.
  - If the RAM is full: drop the beat and set `err_ovf`.
  - Beat counting continues in both cases.
- **Final channel, `wr_ch` = C−1.**
  - No RAM write.
  - When `col` ≥ KS−1: `out_ena` = 1 and `out_data` = `pxl_z`.
  - If `param_relu` is set and `pxl_z[31]` = 1, `out_data` = 0 (−0.0 also becomes +0.0).
- **State machine.**
  - IDLE → RUN on the first `pxl_ena_z` or `pxl_ena_y` after params are latched.
  - RUN → DONE when the last final-channel beat is written; `out_done` pulses with that beat.
  - DONE ignores `pxl_ena_*` (no pointer or counter change) until `rst` or `param_ena`.
- **Pointers.** Wrap modulo 2**AW. Occupancy is held in an AW+1-bit count.
  - Read and write in the same cycle: count unchanged, both pointers advance.
  - Full/empty decisions use the pre-cycle count. A read at count 0 underflows even if a write lands in the same cycle; there is no bypass.
- **Capacity.** Requires N ≤ 2**AW. Otherwise overflow is expected and flagged.

## Timing
- `pxl_y` is valid exactly 1 cycle after `pxl_ena_y` is sampled high (registered RAM read). It holds its value otherwise.
- `out_ena`, `out_data` and `out_done` are registered, 1 cycle after the sampled `pxl_ena_z`.
- `err_*` rise 1 cycle after the offending request.
- Throughput is one read and one write per cycle, with no bubbles.
- `rst` or `param_ena` in mid-frame: the next cycle shows all outputs 0 and an empty buffer. In-flight beats are discarded.

## Structure
- Sub-module `psum_ram`: simple dual-port, 32×2**AW, one write port, one read port with a registered read. Infers block RAM.
- The shared include holds only the FP32 width constant (32) and the ReLU zero constant. No typedefs are needed.
- The top level holds the trackers, pointers, state machine and crop/ReLU output register. Target size is about 200 RTL lines.

## Test plan
- **Single channel, crop.** W=5, H=5, C=1, 15 `pxl_z` beats with values 1..15. Expect 9 `out_ena` beats carrying values 3,4,5,8,9,10,13,14,15. `out_done` coincides with 15. `pxl_y` stays 0.
- **Two-channel replay.** C=2. Channel-0 `pxl_y` reads return 0. Channel-1 reads return the channel-0 `pxl_z` values in order, each 1 cycle after its `pxl_ena_y`. Outputs appear only from channel 1.
- **ReLU.** Final-channel z values 32'hBF800000 and 32'h80000000 give 0 with `param_relu` = 1. With `param_relu` = 0 they pass unchanged. 32'h3F800000 always passes.
- **Overflow/underflow.** AW=3, W=5, H=5, C=2.
  - 15 writes: `err_ovf` sets at the 9th write.
  - A channel-1 read with the RAM empty: `pxl_y` = 0 and `err_udf` = 1.
- **Simultaneous read and write at count 0.** Expect underflow with `pxl_y` = 0, and the written word read on the next request.
- **Mid-frame reset.** Assert `rst` after 7 beats. Next cycle: outputs 0 and flags clear. A subsequent full frame behaves as a fresh one.
